alu_rr_arbiter: RTL and testbench

ALU_RR_ARBITER -- requirements
Module: alu_rr_arbiter

---
 rtl/minigpu_alu_pkg.sv | 22 ++
 rtl/rr_picker.sv | 30 +++
 rtl/alu_rr_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_rr_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minigpu_alu_pkg.sv
// rtl/minigpu_alu_pkg.sv - shared ALU widths, opcodes and arbiter state encoding
package minigpu_alu_pkg;

    localparam int ALU_DATA_W = 16;
    localparam int ALU_FUNC_W = 4;

    typedef enum logic [3:0] {
        ALU_OP_ADD = 4'd0,
        ALU_OP_SUB = 4'd1,
        ALU_OP_AND = 4'd2,
        ALU_OP_OR  = 4'd3,
        ALU_OP_XOR = 4'd4
    } alu_op_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - rotate-priority one-hot picker; search begins at ptr and wraps
module rr_picker #(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               any
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!any && valid[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - shares one pipelined ALU among NUM_REQ requesters, one op in flight
// Define ALU_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module alu_rr_arbiter
    import minigpu_alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = ALU_DATA_W,
    parameter int FUNC_W  = ALU_FUNC_W,
    parameter int ALU_LAT = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*FUNC_W-1:0]  req_func,
    input  logic [NUM_REQ*DATA_W-1:0]  req_a,
    input  logic [NUM_REQ*DATA_W-1:0]  req_b,
    output logic                       alu_en,
    output logic [FUNC_W-1:0]          alu_func,
    output logic [DATA_W-1:0]          alu_a,
    output logic [DATA_W-1:0]          alu_b,
    input  logic [DATA_W-1:0]          alu_out,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [DATA_W-1:0]          resp_data
);

    localparam int IW = $clog2(NUM_REQ);

    arb_state_t          state;
    logic [2:0]          lat_cnt;
    logic [IW-1:0]       pick_ptr;
    logic [IW-1:0]       pick_idx;
    logic [NUM_REQ-1:0]  pick_grant;
    logic                pick_any;
    logic [FUNC_W-1:0]   sel_func;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic                accept;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .valid (req_valid),
        .ptr   (pick_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Ready is held low during reset even though the state already reads IDLE.
    assign accept    = (state == ARB_IDLE) && pick_any && !reset;
    assign req_ready = accept ? pick_grant : '0;

    always_comb begin
        sel_func = '0;
        sel_a    = '0;
        sel_b    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                sel_func = req_func[i*FUNC_W +: FUNC_W];
                sel_a    = req_a[i*DATA_W +: DATA_W];
                sel_b    = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [IW-1:0] ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
        end
    end

    assign pick_ptr = ptr;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARB_IDLE;
            lat_cnt    <= '0;
            alu_en     <= 1'b0;
            alu_func   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (accept) begin
                        state    <= ARB_ISSUE;
                        alu_en   <= 1'b1;
                        alu_func <= sel_func;
                        alu_a    <= sel_a;
                        alu_b    <= sel_b;
                        resp_id  <= pick_idx;
                    end
                end
                ARB_ISSUE: begin
                    state   <= ARB_WAIT;
                    alu_en  <= 1'b0;
                    lat_cnt <= '0;
                end
                ARB_WAIT: begin
                    // The ALU result is valid only on the last WAIT cycle.
                    if (lat_cnt == 3'(ALU_LAT - 1)) begin
                        state      <= ARB_RESP;
                        resp_data  <= alu_out;
                        resp_valid <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                ARB_RESP: begin
                    if (resp_ready) begin
                        state      <= ARB_IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb/tb_alu_rr_arbiter.sv - directed bench with a cycle-level transaction model of the arbiter
module tb_alu_rr_arbiter;

    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int FW  = 4;
    localparam int LAT = 1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*FW-1:0] req_func = '0;
    logic [N*DW-1:0] req_a = '0;
    logic [N*DW-1:0] req_b = '0;
    logic            alu_en;
    logic [FW-1:0]   alu_func;
    logic [DW-1:0]   alu_a, alu_b, alu_out;
    logic            resp_valid;
    logic            resp_ready = 1'b1;
    logic [1:0]      resp_id;
    logic [DW-1:0]   resp_data;

    logic [N-1:0]    z_req_valid = '0;
    logic [N-1:0]    z_req_ready;
    logic [N*FW-1:0] z_req_func = '0;
    logic [N*DW-1:0] z_req_a = '0;
    logic [N*DW-1:0] z_req_b = '0;
    logic            z_alu_en;
    logic [FW-1:0]   z_alu_func;
    logic [DW-1:0]   z_alu_a, z_alu_b, z_alu_out;
    logic            z_resp_valid;
    logic [1:0]      z_resp_id;
    logic [DW-1:0]   z_resp_data;
    logic [DW-1:0]   p1;
    logic [DW-1:0]   z_p [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .FUNC_W(FW), .ALU_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_func(req_func), .req_a(req_a), .req_b(req_b), .alu_en(alu_en),
        .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data)
    );

    alu_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .FUNC_W(FW), .ALU_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_func(z_req_func), .req_a(z_req_a), .req_b(z_req_b), .alu_en(z_alu_en),
        .alu_func(z_alu_func), .alu_a(z_alu_a), .alu_b(z_alu_b), .alu_out(z_alu_out),
        .resp_valid(z_resp_valid), .resp_ready(1'b1), .resp_id(z_resp_id),
        .resp_data(z_resp_data)
    );

    function automatic logic [DW-1:0] alu_f(input logic [FW-1:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (f)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    // Bench ALUs: the result appears exactly LAT cycles after alu_en, garbage otherwise.
    always @(posedge clk) p1 <= alu_en ? alu_f(alu_func, alu_a, alu_b) : 16'hdead;
    assign alu_out = p1;
    always @(posedge clk) begin
        z_p[0] <= z_alu_en ? alu_f(z_alu_func, z_alu_a, z_alu_b) : 16'hdead;
        z_p[1] <= z_p[0];
        z_p[2] <= z_p[1];
    end
    assign z_alu_out = z_p[2];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction model: cycles since acceptance decide every expected output.
    bit            m_busy = 1'b0;
    int            m_t, m_ptr, m_w, m_id, m_id_vis;
    logic [FW-1:0] m_f, m_f_vis;
    logic [DW-1:0] m_a, m_b, m_res, m_a_vis, m_b_vis, m_res_vis;

    initial forever begin
        @(negedge clk);
        if (reset) begin
            m_busy = 1'b0; m_ptr = 0; m_id_vis = 0; m_f_vis = '0;
            m_a_vis = '0; m_b_vis = '0; m_res_vis = '0;
            chk("rst_req_ready", req_ready, 0);
            chk("rst_alu_en", alu_en, 0);
            chk("rst_resp_valid", resp_valid, 0);
        end else if (m_busy) begin
            m_t++;
            if (m_t == 1) begin
                m_a_vis = m_a; m_b_vis = m_b; m_f_vis = m_f; m_id_vis = m_id;
            end
            if (m_t == 2 + LAT) m_res_vis = m_res;
            chk("m_req_ready_busy", req_ready, 0);
            chk("m_alu_en", alu_en, 32'(m_t == 1));
            chk("m_resp_valid", resp_valid, 32'(m_t >= 2 + LAT));
            if (m_t >= 2 + LAT && resp_ready) m_busy = 1'b0;
        end else begin
            m_w = -1;
            for (int k = 0; k < N; k++)
                if (m_w < 0 && req_valid[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
            chk("m_req_ready", req_ready, (m_w >= 0) ? (32'd1 << m_w) : 32'd0);
            chk("m_alu_en_idle", alu_en, 0);
            chk("m_resp_valid_idle", resp_valid, 0);
            if (m_w >= 0) begin
                m_busy = 1'b1; m_t = 0; m_id = m_w;
                m_f = req_func[m_w*FW +: FW];
                m_a = req_a[m_w*DW +: DW];
                m_b = req_b[m_w*DW +: DW];
                m_res = alu_f(m_f, m_a, m_b);
                m_ptr = FIXED ? 0 : (m_w + 1) % N;
            end
        end
        chk("m_alu_a", alu_a, m_a_vis);
        chk("m_alu_b", alu_b, m_b_vis);
        chk("m_alu_func", alu_func, m_f_vis);
        chk("m_resp_id", resp_id, m_id_vis);
        chk("m_resp_data", resp_data, m_res_vis);
    end

    task automatic set_req(input int i, input logic [FW-1:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_func[i*FW +: FW] = f;
        req_a[i*DW +: DW]    = a;
        req_b[i*DW +: DW]    = b;
    endtask

    task automatic wait_ready(input string name, output int idx);
        idx = -1;
        for (int c = 0; c < 30 && idx < 0; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
        end
        if (idx < 0) begin
            checks++; errors++;
            $display("FAIL %s: req_ready timeout, required a grant", name);
        end
    endtask

    task automatic wait_resp(input string name);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            seen = resp_valid;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s: resp_valid timeout, required 1", name);
        end
    endtask

    task automatic drop_and_drain();
        @(posedge clk); #1;
        req_valid = '0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("rst_ready_literal", req_ready, 0);
        chk("rst_resp_data", resp_data, 0);
        req_valid = '0;
        @(posedge clk); #1;
        reset = 1'b0;

        // Single ADD from requester 0
        @(posedge clk); #1;
        set_req(0, 4'd0, 16'd10, 16'd5);
        req_valid = 4'b0001;
        @(negedge clk); chk("t1_ready", req_ready, 4'b0001);
        @(posedge clk); #1; req_valid = '0;
        @(negedge clk); chk("t1_alu_en", alu_en, 1); chk("t1_rv_n1", resp_valid, 0);
        @(negedge clk); chk("t1_alu_en_off", alu_en, 0); chk("t1_rv_n2", resp_valid, 0);
        @(negedge clk); chk("t1_rv_n3", resp_valid, 1);
        chk("t1_id", resp_id, 0); chk("t1_data", resp_data, 16'd15);
        drop_and_drain();

        // Grant order with all four requesters valid from a fresh pointer
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, FW'(i), DW'(100 + 7 * i), DW'(3 + i));
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ready("t2_wait", g);
            chk($sformatf("t2_grant%0d", k), g, FIXED ? 0 : k % N);
        end
        drop_and_drain();

        // Response held while the consumer stalls
        resp_ready = 1'b0;
        set_req(2, 4'd0, 16'd100, 16'd23);
        req_valid = 4'b0100;
        wait_ready("t3_wait", g);
        chk("t3_grant", g, 2);
        @(posedge clk); #1; req_valid = '0;
        wait_resp("t3_resp");
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", resp_valid, 1);
            chk("t3_hold_id", resp_id, 2);
            chk("t3_hold_data", resp_data, 16'd123);
            chk("t3_no_ready", req_ready, 0);
            @(posedge clk); #1;
            if (i == 0) begin
                set_req(0, 4'd4, 16'h00f0, 16'h0ff0);
                req_valid = 4'b0001;
            end
        end
        resp_ready = 1'b1;
        @(negedge clk); chk("t3_hs_valid", resp_valid, 1); chk("t3_hs_ready", req_ready, 0);
        @(negedge clk); chk("t3_done_valid", resp_valid, 0); chk("t3_next_ready", req_ready, 4'b0001);
        drop_and_drain();

        // Reset in WAIT aborts the op; requester 1 follows
        set_req(0, 4'd0, 16'd9, 16'd9);
        req_valid = 4'b0001;
        wait_ready("t4_wait", g);
        @(posedge clk); #1; req_valid = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        set_req(1, 4'd0, 16'd3, 16'd4);
        req_valid = 4'b0010;
        @(negedge clk); chk("t4_rst_rv", resp_valid, 0);
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk); chk("t4_idle_ready", req_ready, 4'b0010);
        @(posedge clk); #1; req_valid = '0;
        wait_resp("t4_resp");
        chk("t4_id", resp_id, 1); chk("t4_data", resp_data, 16'd7);
        drop_and_drain();

        // Pointer wrap after granting the highest index
        set_req(3, 4'd1, 16'd50, 16'd8);
        req_valid = 4'b1000;
        wait_ready("t5_wait3", g);
        chk("t5_grant3", g, 3);
        drop_and_drain();
        req_valid = 4'b1001;
        wait_ready("t5_wait0", g);
        chk("t5_wrap_grant", g, 0);
        drop_and_drain();

        // ALU_LAT=3 instance timing
        z_req_func[0 +: FW] = 4'd0;
        z_req_a[0 +: DW]    = 16'h1234;
        z_req_b[0 +: DW]    = 16'h0101;
        z_req_valid = 4'b0001;
        @(negedge clk); chk("t6_ready", z_req_ready, 4'b0001);
        @(posedge clk); #1; z_req_valid = '0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k < 5) begin
                chk($sformatf("t6_a_n%0d", k), z_alu_a, 16'h1234);
                chk($sformatf("t6_b_n%0d", k), z_alu_b, 16'h0101);
                chk($sformatf("t6_en_n%0d", k), z_alu_en, 32'(k == 1));
                chk($sformatf("t6_rv_n%0d", k), z_resp_valid, 0);
            end else begin
                chk("t6_rv_n5", z_resp_valid, 1);
                chk("t6_id", z_resp_id, 0);
                chk("t6_data", z_resp_data, 16'h1335);
            end
        end
        repeat (4) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
